// File: rtl/uart_frame_parser.sv
// Byte-stream frame parser: SOF/CMD/ADDR/DATA/CRC8 decode with a held validated frame.
// Optional statistics counters are built only when FRAME_PARSER_STATS_EN is defined.
module uart_frame_parser #(
  parameter int         MAX_LEN        = 8,
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter logic [7:0] SOF_BYTE       = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  frame_cmd,
  output logic [31:0] frame_addr,
  output logic [4:0]  frame_len,
  input  logic [3:0]  data_rd_idx,
  output logic [7:0]  data_rd_byte,
  output logic        frame_valid_hold,
  input  logic        frame_consumed,
  output logic        error_pulse,
  output logic [7:0]  error_code,
  output logic [2:0]  state,
  output logic [15:0] stat_ok_cnt,
  output logic [15:0] stat_err_cnt
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  localparam logic [7:0] ERR_NONE    = 8'h00;
  localparam logic [7:0] ERR_CRC     = 8'h01;
  localparam logic [7:0] ERR_TIMEOUT = 8'h02;
  localparam logic [7:0] ERR_LEN     = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_DATA  = 3'd3,
    S_CRC   = 3'd4,
    S_VALID = 3'd5,
    S_ERROR = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [31:0]     addr_q, addr_d;
  logic [4:0]      len_q, len_d;
  logic [7:0]      crc_q, crc_d;
  logic [3:0]      byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      err_code_q, err_code_d;

  logic [7:0]      payload_q [16];
  logic            payload_we;

  logic            accept;
  logic            in_frame;
  logic            timed_out;
  logic [TO_W-1:0] to_inc;
  logic [4:0]      cmd_len;

  // One CRC8 step over a whole byte: poly 0x07, MSB first, no reflection.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  assign rx_ready = (state_q != S_VALID) && (state_q != S_ERROR);
  assign accept   = rx_valid && rx_ready;
  assign in_frame = (state_q == S_CMD) || (state_q == S_ADDR) ||
                    (state_q == S_DATA) || (state_q == S_CRC);
  assign to_inc   = to_cnt_q + TO_W'(1);
  assign cmd_len  = {1'b0, rx_data[3:0]} + 5'd1;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    len_d      = len_q;
    crc_d      = crc_q;
    byte_cnt_d = byte_cnt_q;
    to_cnt_d   = '0;
    err_code_d = err_code_q;
    payload_we = 1'b0;
    timed_out  = 1'b0;

    // An accepted byte in the expiry cycle clears the counter and wins.
    if (in_frame) begin
      if (accept) begin
        to_cnt_d = '0;
      end else begin
        to_cnt_d  = to_inc;
        timed_out = (to_inc == TO_LIMIT);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (accept && rx_data == SOF_BYTE) begin
          state_d = S_CMD;
          crc_d   = 8'h00;
        end
      end
      S_CMD: begin
        if (accept) begin
          cmd_d      = rx_data;
          len_d      = cmd_len;
          crc_d      = crc8_update(crc_q, rx_data);
          byte_cnt_d = 4'd0;
          if (!rx_data[7] && int'(cmd_len) > MAX_LEN) begin
            state_d    = S_ERROR;
            err_code_d = ERR_LEN;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (accept) begin
          addr_d[{byte_cnt_q[1:0], 3'b000} +: 8] = rx_data;
          crc_d = crc8_update(crc_q, rx_data);
          if (byte_cnt_q == 4'd3) begin
            byte_cnt_d = 4'd0;
            state_d    = cmd_q[7] ? S_CRC : S_DATA;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          payload_we = 1'b1;
          crc_d      = crc8_update(crc_q, rx_data);
          // cmd[3:0] is LEN-1, i.e. the index of the last payload byte.
          if (byte_cnt_q == cmd_q[3:0]) begin
            byte_cnt_d = 4'd0;
            state_d    = S_CRC;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end
      S_CRC: begin
        if (accept) begin
          if (rx_data == crc_q) begin
            state_d    = S_VALID;
            err_code_d = ERR_NONE;
          end else begin
            state_d    = S_ERROR;
            err_code_d = ERR_CRC;
          end
        end
      end
      S_VALID: begin
        if (frame_consumed) begin
          state_d = S_IDLE;
        end
      end
      S_ERROR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (timed_out) begin
      state_d    = S_ERROR;
      err_code_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      crc_q      <= '0;
      byte_cnt_q <= '0;
      to_cnt_q   <= '0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      crc_q      <= crc_d;
      byte_cnt_q <= byte_cnt_d;
      to_cnt_q   <= to_cnt_d;
      err_code_q <= err_code_d;
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (payload_we) begin
      payload_q[byte_cnt_q] <= rx_data;
    end
  end

  assign data_rd_byte     = payload_q[data_rd_idx];
  assign frame_cmd        = cmd_q;
  assign frame_addr       = addr_q;
  assign frame_len        = len_q;
  assign frame_valid_hold = (state_q == S_VALID);
  assign error_pulse      = (state_q == S_ERROR);
  assign error_code       = err_code_q;
  assign state            = state_q;

`ifdef FRAME_PARSER_STATS_EN
  logic [15:0] ok_cnt_q, ok_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    ok_cnt_d  = ok_cnt_q;
    err_cnt_d = err_cnt_q;
    if (state_d == S_VALID && state_q != S_VALID && ok_cnt_q != 16'hFFFF) begin
      ok_cnt_d = ok_cnt_q + 16'd1;
    end
    if (state_d == S_ERROR && state_q != S_ERROR && err_cnt_q != 16'hFFFF) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign stat_ok_cnt  = ok_cnt_q;
  assign stat_err_cnt = err_cnt_q;
`else
  assign stat_ok_cnt  = '0;
  assign stat_err_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: directed frames plus randomized frames
// checked against a CRC/length reference model.
module tb_uart_frame_parser;

  localparam int         MAX_LEN = 8;
  localparam int         TMO     = 16;
  localparam logic [7:0] SOF     = 8'hA5;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  frame_cmd;
  logic [31:0] frame_addr;
  logic [4:0]  frame_len;
  logic [3:0]  data_rd_idx;
  logic [7:0]  data_rd_byte;
  logic        frame_valid_hold;
  logic        frame_consumed;
  logic        error_pulse;
  logic [7:0]  error_code;
  logic [2:0]  state;
  logic [15:0] stat_ok_cnt;
  logic [15:0] stat_err_cnt;

  uart_frame_parser #(
    .MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO), .SOF_BYTE(SOF)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_cmd(frame_cmd), .frame_addr(frame_addr), .frame_len(frame_len),
    .data_rd_idx(data_rd_idx), .data_rd_byte(data_rd_byte),
    .frame_valid_hold(frame_valid_hold), .frame_consumed(frame_consumed),
    .error_pulse(error_pulse), .error_code(error_code), .state(state),
    .stat_ok_cnt(stat_ok_cnt), .stat_err_cnt(stat_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             is_err;
    logic [7:0]       code;
    logic [7:0]       cmd;
    logic [31:0]      addr;
    logic [4:0]       len;
    logic [15:0][7:0] pay;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] st_trace[$];
  int checks   = 0;
  int failures = 0;
  int ack_cnt  = 0;
  int ack_seen = 0;
  int n_ok     = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Bit-serial LFSR view of CRC8 (poly x^8+x^2+x+1) over the whole message.
  function automatic logic [7:0] ref_crc(input logic [7:0] msg[$]);
    logic [7:0] r = 8'h00;
    logic fb;
    foreach (msg[i]) begin
      for (int j = 7; j >= 0; j--) begin
        fb = r[7] ^ msg[i][j];
        r  = {r[6:0], 1'b0};
        if (fb) r = r ^ 8'h07;
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    rx_valid = 1'b0;
    check("accept_bound", (n >= 50), 1'b0);
  endtask

  task automatic finish_valid();
    int n = 0;
    while (!frame_valid_hold && n < 50) begin
      tick();
      n++;
    end
    check("hold_seen", frame_valid_hold, 1'b1);
    n = 0;
    while (ack_cnt <= ack_seen && n < 100) begin
      tick();
      n++;
    end
    check("monitor_ack", (ack_cnt > ack_seen), 1'b1);
    ack_seen = ack_cnt;
    check("ready_low_in_valid", rx_ready, 1'b0);
    check("state_still_valid", state, 3'd5);
    frame_consumed = 1'b1;
    tick();
    frame_consumed = 1'b0;
    check("idle_after_consume", state, 3'd0);
    check("hold_cleared", frame_valid_hold, 1'b0);
  endtask

  // Builds a frame, predicts its outcome from the frame rules, queues that
  // prediction, then drives SOF + body + CRC (crc_xor != 0 corrupts the CRC).
  task automatic run_frame(input logic [7:0] cmd, input logic [31:0] addr,
                           input logic [15:0][7:0] pay, input logic [7:0] crc_xor,
                           input int maxgap, input int long_gap_idx);
    logic [7:0] body[$];
    logic [7:0] b;
    exp_t e;
    int   len;
    logic bad_len;
    len     = int'(cmd[3:0]) + 1;
    bad_len = !cmd[7] && (len > MAX_LEN);
    body.push_back(cmd);
    for (int k = 0; k < 4; k++) body.push_back(addr[8*k +: 8]);
    if (!cmd[7]) for (int k = 0; k < len; k++) body.push_back(pay[k]);
    b = ref_crc(body);
    body.push_back(b ^ crc_xor);
    e      = '0;
    e.cmd  = cmd;
    e.addr = addr;
    e.len  = 5'(len);
    e.pay  = pay;
    if (bad_len) begin
      e.is_err = 1'b1;
      e.code   = 8'h03;
    end else if (crc_xor != 8'h00) begin
      e.is_err = 1'b1;
      e.code   = 8'h01;
    end
    sb.push_back(e);
    if (e.is_err) n_err++;
    else n_ok++;
    st_trace.delete();
    send_byte(SOF, $urandom_range(0, maxgap));
    st_trace.push_back(state);
    foreach (body[k]) begin
      b = body[k];
      if (bad_len && k > 0 && b == SOF) b = 8'h5A;
      send_byte(b, (k == long_gap_idx) ? TMO - 1 : $urandom_range(0, maxgap));
      st_trace.push_back(state);
    end
    if (!e.is_err) finish_valid();
    else repeat (2) tick();
  endtask

  // Monitor: pops a prediction whenever the DUT reports a frame or an error.
  initial begin : monitor
    exp_t e;
    logic seen;
    logic prev_err;
    seen        = 1'b0;
    prev_err    = 1'b0;
    data_rd_idx = 4'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        seen     = 1'b0;
        prev_err = 1'b0;
      end else begin
        if (prev_err) check("error_pulse_one_cycle", error_pulse, 1'b0);
        prev_err = error_pulse;
        if (error_pulse) begin
          if (sb.size() == 0) check("unexpected_error", 1'b1, 1'b0);
          else begin
            e = sb.pop_front();
            check("error_expected", e.is_err, 1'b1);
            check("error_code", error_code, e.code);
            check("error_state", state, 3'd6);
            check("error_no_hold", frame_valid_hold, 1'b0);
          end
        end
        if (!frame_valid_hold) seen = 1'b0;
        else if (!seen) begin
          seen = 1'b1;
          if (sb.size() == 0) check("unexpected_frame", 1'b1, 1'b0);
          else begin
            e = sb.pop_front();
            check("frame_expected", e.is_err, 1'b0);
            check("frame_cmd", frame_cmd, e.cmd);
            check("frame_addr", frame_addr, e.addr);
            check("frame_len", frame_len, e.len);
            check("valid_error_code", error_code, 8'h00);
            if (!e.cmd[7]) begin
              for (int i = 0; i < int'(e.len); i++) begin
                data_rd_idx = 4'(i);
                #1;
                check("payload_byte", data_rd_byte, e.pay[i]);
              end
            end
          end
          ack_cnt++;
        end
      end
    end
  end

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [15:0][7:0] pay;
    logic [7:0] cmd;
    logic [7:0] g;
    int kind;
    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; frame_consumed = 1'b0;
    repeat (3) tick();
    check("rst_state", state, 3'd0);
    check("rst_rx_ready", rx_ready, 1'b1);
    check("rst_hold", frame_valid_hold, 1'b0);
    check("rst_error_pulse", error_pulse, 1'b0);
    check("rst_error_code", error_code, 8'h00);
    check("rst_fields", {frame_cmd, frame_len, 19'h0} | frame_addr, 32'h0);
    check("rst_stats", {stat_ok_cnt, stat_err_cnt}, 32'h0);
    rst = 1'b1;
    tick();

    // Reset mid-frame aborts silently and clears latched fields.
    send_byte(SOF, 0); send_byte(8'h03, 0); send_byte(8'h12, 0);
    check("midframe_state", state, 3'd2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midreset_state", state, 3'd0);
    check("midreset_len", frame_len, 5'd0);
    check("midreset_code", error_code, 8'h00);

    // Minimal write frame with no gaps: full state trace.
    pay = '0;
    run_frame(8'h00, 32'h0, pay, 8'h00, 0, -1);
    check("trace_len", st_trace.size(), 8);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] exp_st [8] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5};
      if (i < st_trace.size()) check("trace_state", st_trace[i], exp_st[i]);
    end
    check("payload0_after", data_rd_byte, 8'h00);

    // Same frame with CRC byte 01.
    run_frame(8'h00, 32'h0, pay, 8'h01, 0, -1);
    check("badcrc_last_state", st_trace[st_trace.size()-1], 3'd6);
    check("badcrc_back_idle", state, 3'd0);
    check("badcrc_code_held", error_code, 8'h01);

    // Read frame skips DATA.
    run_frame(8'h80, 32'h12345678, pay, 8'h00, 0, -1);
    check("read_skips_data", st_trace[5], 3'd4);

    // Timeout: exactly TMO idle cycles after the CMD byte.
    sb.push_back(exp_t'({1'b1, 8'h02, 8'h00, 32'h0, 5'd0, 128'h0}));
    n_err++;
    send_byte(SOF, 0); send_byte(8'h01, 0);
    repeat (TMO - 1) tick();
    check("timeout_not_yet", state, 3'd2);
    tick();
    check("timeout_state", state, 3'd6);
    check("timeout_code", error_code, 8'h02);
    tick();
    check("timeout_idle", state, 3'd0);

    // A byte on the last idle cycle prevents the timeout.
    pay[0] = 8'hC3; pay[1] = 8'h3C;
    run_frame(8'h01, 32'hCAFE0001, pay, 8'h00, 0, 1);
    check("late_byte_accepted", st_trace[2], 3'd2);

    // Write length 16 exceeds MAX_LEN: error right after CMD, rest discarded.
    for (int i = 0; i < 16; i++) pay[i] = 8'(i * 17 + 3);
    run_frame(8'h0F, 32'h0, pay, 8'h00, 0, -1);
    check("badlen_after_cmd", st_trace[1], 3'd6);
    check("badlen_discard_idle", state, 3'd0);

    // Leading garbage, then a good frame.
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    check("garbage_ignored", state, 3'd0);
    pay[0] = 8'hAB; pay[1] = 8'hCD; pay[2] = SOF;
    run_frame(8'h02, 32'h00A5A500, pay, 8'h00, 1, -1);

    // Randomized frames.
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 3);
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom);
        if (g == SOF) g = 8'h3C;
        send_byte(g, $urandom_range(0, 3));
      end
      for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
      case (kind)
        0: cmd = {1'b0, 3'($urandom), 4'($urandom_range(0, 7))};
        1: cmd = {1'b1, 3'($urandom), 4'($urandom)};
        2: cmd = $urandom_range(0, 1) ? {1'b1, 3'($urandom), 4'($urandom)}
                                      : {1'b0, 3'($urandom), 4'($urandom_range(0, 7))};
        default: cmd = {1'b0, 3'($urandom), 4'($urandom_range(8, 15))};
      endcase
      run_frame(cmd, $urandom, pay, (kind == 2) ? 8'($urandom_range(1, 255)) : 8'h00, 3, -1);
    end

    repeat (5) tick();
    check("scoreboard_drained", sb.size(), 0);
`ifdef FRAME_PARSER_STATS_EN
    check("stat_ok", stat_ok_cnt, 16'(n_ok));
    check("stat_err", stat_err_cnt, 16'(n_err));
`else
    check("stat_ok_tied", stat_ok_cnt, 16'h0);
    check("stat_err_tied", stat_err_cnt, 16'h0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
